// File: rtl/demux_pkg.sv
// Shared types and defaults for the lane-steering / serial-to-parallel blocks.
package demux_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam int DEMUX_WIDTH = 8;

endpackage

// File: rtl/demux18.sv
// One-hot lane decoder: raises exactly one write-enable (lane sel) when en is high.
module demux18 #(
  parameter int WIDTH = demux_pkg::DEMUX_WIDTH,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] lane_en
);

  // WIDTH is a power of two, so every sel code addresses a real lane.
  always_comb begin
    lane_en = '0;
    if (en) lane_en[sel] = 1'b1;
  end

endmodule

// File: rtl/demux18_sipo.sv
// Serial-in parallel-out collector: steers accepted bits to lane sel (LSB first)
// and presents each completed word on a valid/ready output register.
//
// state   | meaning
// COLLECT | accepting bits into the shadow register, in_ready=1
// HOLD    | complete word on out_data, out_valid=1, input stalled
module demux18_sipo
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t           state;
  state_t           next_state;
  logic [SEL_W-1:0] sel_q;
  // Top lane goes straight into out_data, so the shadow only keeps the lower lanes.
  logic [WIDTH-2:0] shadow;
  logic [WIDTH-1:0] lane_en;
  logic             accept;
  logic             word_done;

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == HOLD);
  assign sel       = sel_q;
  // clear wins over a bit presented in the same cycle.
  assign accept    = in_valid & in_ready & ~clear;
  assign word_done = lane_en[WIDTH-1];

  demux18 #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_lane_dec (
    .en      (accept),
    .sel     (sel_q),
    .lane_en (lane_en)
  );

  always_comb begin
    next_state = state;
    case (state)
      COLLECT: if (word_done) next_state = HOLD;
      HOLD:    if (out_ready) next_state = COLLECT;
      default: next_state = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sel_q <= '0;
    end else if (accept) begin
      sel_q <= sel_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shadow <= '0;
    end else begin
      for (int k = 0; k < WIDTH - 1; k++) begin
        if (lane_en[k]) shadow[k] <= in_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
    end else if (word_done) begin
      out_data <= {in_bit, shadow};
    end
  end

endmodule
